tlp_rr_arbiter: RTL and testbench
=================================

// Module: tlp_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one DATA_W-bit transaction-layer datapath among NUM_REQ
//  requesters (virtual-channel / source queues). Grants one requester at a time for a burst of
//  up to MAX_BURST beats and forwards its data under a valid/ready handshake.
//  Sits between the per-source queues and the downstream TLP builder / change counters.
// PARAMETERS
//  NUM_REQ    4   number of requesters (>=2)
//  DATA_W     12  beat width, per requester and on the output
//  MAX_BURST  4   max beats per grant before forced rotation (>=1)
//  CNT_W      5   width of each per-requester grant counter (GRANT_STATS_EN only)
// PORTS
//  clk        in   1               clock, all logic on posedge
//  reset      in   1               synchronous, active-low
//  req        in   NUM_REQ         request per requester; bit i = requester i has a beat ready
//  data_in    in   NUM_REQ*DATA_W  beat of requester i at [i*DATA_W +: DATA_W]
//  last       in   NUM_REQ         bit i = current beat of requester i ends its packet
//  out_ready  in   1               downstream accepts the beat this cycle
//  gnt        out  NUM_REQ         registered one-hot grant (all zero when idle)
//  out_valid  out  1               beat on out_data is valid
//  out_data   out  DATA_W          beat of the granted requester
//  busy       out  1               1 while state==GRANT
//  grant_cnt  out  NUM_REQ*CNT_W   per-requester grant counters (GRANT_STATS_EN only)
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE, gnt=0, ptr=NUM_REQ-1, beat_cnt=0, grant_cnt=0.
//    Reset overrides everything and aborts a burst in progress; the cut beat is not replayed.
//  - FSM IDLE: if |req, select the first set req bit scanning ptr+1, ptr+2, ... (mod NUM_REQ);
//    next cycle gnt = onehot(sel), state=GRANT, beat_cnt=0. If req==0, stay IDLE, gnt=0.
//  - Latency: req rising in IDLE at cycle N -> gnt and out_valid at cycle N+1.
//  - FSM GRANT (granted index g):
//    out_valid = req[g] (combinational); out_data = data_in slice g (combinational).
//    Transfer = out_valid & out_ready; beat_cnt increments on each transfer.
//    Release at the posedge that sees: transfer & last[g], OR transfer with
//    beat_cnt==MAX_BURST-1, OR req[g]==0 (requester withdrew).
//    On release: ptr=g, gnt=0, state=IDLE (one idle bubble between grants, always).
//  - out_ready low: hold beat, no count, no release unless req[g] drops.
//  - Requests of non-granted requesters are ignored during GRANT; their data is never
//    forwarded. out_valid=0 and out_data=0 in IDLE.
//  - Fairness: after g is served, g has lowest priority next arbitration; a requester
//    holding req continuously is granted within NUM_REQ arbitrations.
//  - beat_cnt width = clog2(MAX_BURST)+1; never exceeds MAX_BURST-1.
// CONFIGURATION
//  GRANT_STATS_EN defined: grant_cnt present; counter i increments by 1 on each IDLE->GRANT
//    entry for requester i, wraps modulo 2^CNT_W (31 -> 0 for CNT_W=5); cleared by reset.
//  GRANT_STATS_EN undefined: grant_cnt port and counters absent; all other behaviour identical.
// TESTING
//  1 reset=0 two cycles, req=4'b1111 -> gnt=0, out_valid=0; after reset=1, gnt=4'b0001 next cycle.
//  2 req=4'b0101, out_ready=1, last=0 always -> grants 0 (4 beats), idle, 2 (4 beats), idle, 0 ...
//  3 req[1] only, data 12'hABC, last on beat 2, out_ready=1 -> out_data=ABC x2, gnt drops, 1 idle cycle.
//  4 grant on 3, out_ready=0 for 3 cycles -> out_valid=1, data held, beat_cnt unchanged, no rotate.
//  5 grant on 2, req[2] drops mid-burst -> release next posedge, ptr=2, next grant goes to 3 if requesting.
//  6 GRANT_STATS_EN, 33 single-beat grants to requester 0 -> grant_cnt[0]=1; reset mid-burst -> all 0, IDLE.

Source files
------------

// File: rtl/tlp_rr_arbiter.sv
// Round-robin arbiter sharing one transaction-layer datapath among NUM_REQ requesters,
// granting bursts of up to MAX_BURST beats. Optional per-requester grant counters: GRANT_STATS_EN.
module tlp_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 12,
  parameter int MAX_BURST = 4
`ifdef GRANT_STATS_EN
  , parameter int CNT_W   = 5
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  input  logic [NUM_REQ-1:0]        last,
  input  logic                      out_ready,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      busy
`ifdef GRANT_STATS_EN
  , output logic [NUM_REQ*CNT_W-1:0] grant_cnt
`endif
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int BEAT_W = $clog2(MAX_BURST) + 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0]  PTR_RST   = IDX_W'(NUM_REQ - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    g_q, g_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;

  logic                sel_vld;
  logic [IDX_W-1:0]    sel_idx;
  logic                xfer;
  logic                rel;

  // Rotating priority scan: the requester just served (ptr) is examined last.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    sel_vld  = 1'b0;
    sel_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(ptr_q) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!sel_vld && req[cand_idx]) begin
        sel_vld = 1'b1;
        sel_idx = cand_idx;
      end
    end
  end

  assign xfer = out_valid & out_ready;
  assign rel  = busy & ((xfer & (last[g_q] | (beat_cnt_q == BEAT_LAST))) | ~req[g_q]);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; it is sampled only on the clock edge, like any other input.
    if (!reset) begin
      state_q    <= IDLE;
      ptr_q      <= PTR_RST;
      g_q        <= '0;
      gnt_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      g_q        <= g_d;
      gnt_q      <= gnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    g_d        = g_q;
    gnt_d      = gnt_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (sel_vld) begin
          state_d    = GRANT;
          g_d        = sel_idx;
          gnt_d      = NUM_REQ'(1) << sel_idx;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          // Always drop to IDLE: one bubble between grants keeps arbitration registered.
          state_d    = IDLE;
          ptr_d      = g_q;
          gnt_d      = '0;
          beat_cnt_d = '0;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        end
      end
    endcase
  end

  // Outputs.
  always_comb begin
    gnt       = gnt_q;
    busy      = (state_q == GRANT);
    out_valid = 1'b0;
    out_data  = '0;
    if (state_q == GRANT) begin
      out_valid = req[g_q];
      out_data  = data_in[int'(g_q)*DATA_W +: DATA_W];
    end
  end

`ifdef GRANT_STATS_EN
  logic [NUM_REQ*CNT_W-1:0] grant_cnt_q;

  // Counts IDLE->GRANT entries per requester; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!reset) begin
      grant_cnt_q <= '0;
    end else if ((state_q == IDLE) && sel_vld) begin
      grant_cnt_q[int'(sel_idx)*CNT_W +: CNT_W] <=
        grant_cnt_q[int'(sel_idx)*CNT_W +: CNT_W] + CNT_W'(1);
    end
  end

  assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_tlp_rr_arbiter.sv
// Directed bench for tlp_rr_arbiter: per-cycle grant checks plus a beat scoreboard.
// Build with GRANT_STATS_EN defined to also check the grant counters.
module tb_tlp_rr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 12;
  localparam int MAX_BURST = 4;
  localparam int CNT_W     = 5;

  logic                      clk;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] data_in;
  logic [NUM_REQ-1:0]        last;
  logic                      out_ready;
  logic [NUM_REQ-1:0]        gnt;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      busy;
`ifdef GRANT_STATS_EN
  logic [NUM_REQ*CNT_W-1:0]  grant_cnt;
`endif

  tlp_rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
`ifdef GRANT_STATS_EN
    , .CNT_W   (CNT_W)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data_in   (data_in),
    .last      (last),
    .out_ready (out_ready),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy)
`ifdef GRANT_STATS_EN
    , .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]        idx;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_beats(input int idx, input logic [DATA_W-1:0] d, input int n);
    beat_t b;
    b.idx  = 2'(idx);
    b.data = d;
    for (int i = 0; i < n; i++) exp_q.push_back(b);
  endtask

  task automatic set_data(input int i, input logic [DATA_W-1:0] v);
    data_in[i*DATA_W +: DATA_W] = v;
  endtask

  // Check this cycle's outputs mid-cycle, then advance past one posedge.
  task automatic tick(input string name, input logic [NUM_REQ-1:0] exp_gnt, input logic exp_valid);
    @(negedge clk);
    check({name, ".gnt"}, gnt, exp_gnt);
    check({name, ".valid"}, out_valid, exp_valid);
    check({name, ".busy"}, busy, |exp_gnt);
    if (exp_gnt == '0) check({name, ".idle_data"}, out_data, '0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req       = '0;
    last      = '0;
    out_ready = 1'b0;
    tick("rst", '0, 1'b0);
    reset     = 1'b1;
  endtask

  // Scoreboard monitor: every accepted beat must match the next expected one.
  always @(negedge clk) begin
    beat_t e;
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got beat %0h gnt %b expected none", out_data, gnt);
      end else begin
        e = exp_q.pop_front();
        check("sb.gnt", gnt, 64'(4'b0001 << e.idx));
        check("sb.data", out_data, e.data);
      end
    end
  end

  initial begin
    reset     = 1'b0;
    req       = 4'b1111;
    last      = '0;
    out_ready = 1'b0;
    data_in   = '0;
    set_data(0, 12'h100);
    set_data(1, 12'h211);
    set_data(2, 12'h322);
    set_data(3, 12'hD3E);
    @(posedge clk);
    #1;

    // Reset holds off grants; first grant after release goes to requester 0.
    tick("t1_rst0", '0, 1'b0);
    tick("t1_rst1", '0, 1'b0);
    reset = 1'b1;
    tick("t1_rel", '0, 1'b0);
    tick("t1_first", 4'b0001, 1'b1);
    req = '0;
    tick("t1_drop", 4'b0001, 1'b0);
    tick("t1_idle", '0, 1'b0);

    // Two requesters, full bursts, alternating with one bubble in between.
    do_reset();
    req       = 4'b0101;
    out_ready = 1'b1;
    expect_beats(0, 12'h100, 4);
    expect_beats(2, 12'h322, 4);
    expect_beats(0, 12'h100, 4);
    tick("t2_arb", '0, 1'b0);
    repeat (4) tick("t2_g0", 4'b0001, 1'b1);
    tick("t2_bub0", '0, 1'b0);
    repeat (4) tick("t2_g2", 4'b0100, 1'b1);
    tick("t2_bub1", '0, 1'b0);
    repeat (4) tick("t2_g0b", 4'b0001, 1'b1);
    req = '0;
    tick("t2_end", '0, 1'b0);

    // Packet end on beat 2 releases early; re-grant after exactly one idle cycle.
    req = 4'b0010;
    set_data(1, 12'hABC);
    expect_beats(1, 12'hABC, 2);
    tick("t3_arb", '0, 1'b0);
    tick("t3_b1", 4'b0010, 1'b1);
    last = 4'b0010;
    tick("t3_b2", 4'b0010, 1'b1);
    last      = '0;
    out_ready = 1'b0;
    tick("t3_bub", '0, 1'b0);
    tick("t3_regnt", 4'b0010, 1'b1);
    req = '0;
    tick("t3_drop", 4'b0010, 1'b0);
    tick("t3_idle", '0, 1'b0);

    // Back-pressure: beat held, burst length unaffected by stall cycles.
    req = 4'b1000;
    tick("t4_arb", '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("t4_hold", out_data, 12'hD3E);
      tick("t4_stall", 4'b1000, 1'b1);
    end
    out_ready = 1'b1;
    expect_beats(3, 12'hD3E, 4);
    repeat (4) tick("t4_burst", 4'b1000, 1'b1);
    req = '0;
    tick("t4_end", '0, 1'b0);

    // Withdrawal mid-burst; the withdrawn requester then has lowest priority.
    req = 4'b1100;
    set_data(2, 12'h2A5);
    expect_beats(2, 12'h2A5, 2);
    tick("t5_arb", '0, 1'b0);
    tick("t5_b1", 4'b0100, 1'b1);
    tick("t5_b2", 4'b0100, 1'b1);
    req = 4'b1000;
    tick("t5_wd", 4'b0100, 1'b0);
    tick("t5_bub", '0, 1'b0);
    expect_beats(3, 12'hD3E, 1);
    tick("t5_g3", 4'b1000, 1'b1);
    req = '0;
    tick("t5_wd3", 4'b1000, 1'b0);
    tick("t5_end", '0, 1'b0);

    // 33 single-beat grants to requester 0, then a reset that cuts a burst.
    do_reset();
    req       = 4'b0001;
    last      = 4'b0001;
    out_ready = 1'b1;
    for (int n = 0; n < 33; n++) begin
      expect_beats(0, 12'h100, 1);
      tick("t6_idle", '0, 1'b0);
      tick("t6_gnt", 4'b0001, 1'b1);
    end
`ifdef GRANT_STATS_EN
    check("t6_cnt0_wrap", grant_cnt[0 +: CNT_W], 5'd1);
    check("t6_cnt_others", grant_cnt[NUM_REQ*CNT_W-1:CNT_W], '0);
`endif
    last = '0;
    expect_beats(0, 12'h100, 1);
    tick("t6_arb", '0, 1'b0);
    tick("t6_b1", 4'b0001, 1'b1);
    reset     = 1'b0;
    out_ready = 1'b0;
    tick("t6_mid", 4'b0001, 1'b1);
    reset = 1'b1;
    req   = '0;
`ifdef GRANT_STATS_EN
    check("t6_cnt_cleared", grant_cnt, '0);
`endif
    tick("t6_after", '0, 1'b0);
    out_ready = 1'b1;
    tick("t6_quiet", '0, 1'b0);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
